// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and shared-ALU signals of alu_arbiter
interface alu_arbiter_if;
   logic [1:0] req_valid, req_ready, req_ci, req_ir, req_il;
   logic [7:0] req_sel, req_a, req_b;
   logic [3:0] req_cnt;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_co;
   logic [3:0] rsp_f;
   logic [3:0] alu_sel, alu_a, alu_b, alu_f;
   logic       alu_ci, alu_ir, alu_il, alu_co;
   modport master (
      output req_valid, req_sel, req_ci, req_ir, req_il, req_cnt, req_a, req_b, rsp_ready, alu_f, alu_co,
      input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_co, alu_sel, alu_a, alu_b, alu_ci, alu_ir, alu_il
   );
   modport slave (
      input  req_valid, req_sel, req_ci, req_ir, req_il, req_cnt, req_a, req_b, rsp_ready, alu_f, alu_co,
      output req_ready, rsp_valid, rsp_id, rsp_f, rsp_co, alu_sel, alu_a, alu_b, alu_ci, alu_ir, alu_il
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational 4-bit ALU between two requesters
module alu_arbiter #(
   parameter logic RR_INIT = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t     state_q, state_d;
   logic       last_q, last_d, ci_q, ci_d, ir_q, ir_d, il_q, il_d, id_q, id_d, co_q, co_d;
   logic [3:0] sel_q, sel_d, a_q, a_d, b_q, b_d, f_q, f_d;
   logic [1:0] cnt_q, cnt_d, grant;
   logic       gid, exec;
   // on contention the requester that was not served last wins
   assign grant = (bus.req_valid == 2'b11) ? (last_q ? 2'b01 : 2'b10) : bus.req_valid;
   assign gid = grant[1];
   assign exec = (state_q == EXEC);
   assign bus.req_ready = (rst_n && state_q == IDLE) ? grant : 2'b00;
   assign bus.alu_sel = exec ? sel_q : 4'd0;
   assign bus.alu_a = exec ? a_q : 4'd0;
   assign bus.alu_b = exec ? b_q : 4'd0;
   assign bus.alu_ci = exec & ci_q;
   assign bus.alu_ir = exec & ir_q;
   assign bus.alu_il = exec & il_q;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id = id_q;
   assign bus.rsp_f = f_q;
   assign bus.rsp_co = co_q;
   always_comb begin
      state_d = state_q;
      last_d = last_q;
      sel_d = sel_q;
      ci_d = ci_q;
      ir_d = ir_q;
      il_d = il_q;
      a_d = a_q;
      b_d = b_q;
      cnt_d = cnt_q;
      id_d = id_q;
      f_d = f_q;
      co_d = co_q;
      case (state_q)
         IDLE: if (|grant) begin
            sel_d = gid ? bus.req_sel[7:4] : bus.req_sel[3:0];
            a_d = gid ? bus.req_a[7:4] : bus.req_a[3:0];
            b_d = gid ? bus.req_b[7:4] : bus.req_b[3:0];
            cnt_d = gid ? bus.req_cnt[3:2] : bus.req_cnt[1:0];
            ci_d = bus.req_ci[gid];
            ir_d = bus.req_ir[gid];
            il_d = bus.req_il[gid];
            id_d = gid;
            state_d = EXEC;
         end
         // shifts feed the ALU result back into the operand until the count is used up
         EXEC: if (sel_q[3] && cnt_q != 2'd0) begin
            a_d = bus.alu_f;
            cnt_d = cnt_q - 2'd1;
         end else begin
            f_d = bus.alu_f;
            co_d = bus.alu_co;
            state_d = RESP;
         end
         RESP: if (bus.rsp_ready) begin
            last_d = id_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q <= RR_INIT;
         sel_q <= '0;
         ci_q <= 1'b0;
         ir_q <= 1'b0;
         il_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         cnt_q <= '0;
         id_q <= 1'b0;
         f_q <= '0;
         co_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         sel_q <= sel_d;
         ci_q <= ci_d;
         ir_q <= ir_d;
         il_q <= il_d;
         a_q <= a_d;
         b_q <= b_d;
         cnt_q <= cnt_d;
         id_q <= id_d;
         f_q <= f_d;
         co_q <= co_d;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
   logic clk, rst_n;
   int   tests, fails;
   logic last_m;
   logic [3:0] got_f;
   logic got_co, got_id;
   alu_arbiter_if bus ();
   alu_arbiter #(.RR_INIT(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // shared ALU: {co, f}
   function automatic logic [4:0] alu_ref(input logic [3:0] s, a, b, input logic ci, ir, il);
      logic [4:0] r;
      case (s[3:2])
         2'b00: r = {1'b0, a} + {1'b0, (s[1:0] == 2'b00) ? 4'h0 : (s[1:0] == 2'b01) ? b : (s[1:0] == 2'b10) ? ~b : 4'hF} + {4'd0, ci};
         2'b01: r = {1'b0, (s[1:0] == 2'b00) ? (a & b) : (s[1:0] == 2'b01) ? (a | b) : (s[1:0] == 2'b10) ? (a ^ b) : ~a};
         2'b10: r = {a[0], ir, a[3:1]};
         default: r = {a[3], a[2:0], il};
      endcase
      return r;
   endfunction
   assign {bus.alu_co, bus.alu_f} = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_ci, bus.alu_ir, bus.alu_il);
   function automatic logic [4:0] op_ref(input logic [3:0] s, a, b, input logic ci, ir, il, input logic [1:0] c);
      logic [4:0] r;
      r = alu_ref(s, a, b, ci, ir, il);
      if (s[3]) for (int k = 0; k < int'(c); k++) r = alu_ref(s, r[3:0], b, ci, ir, il);
      return r;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic set_req(input int i, input logic [3:0] s, a, b, input logic ci, ir, il, input logic [1:0] c);
      bus.req_sel[4*i +: 4] = s;
      bus.req_a[4*i +: 4] = a;
      bus.req_b[4*i +: 4] = b;
      bus.req_cnt[2*i +: 2] = c;
      bus.req_ci[i] = ci;
      bus.req_ir[i] = ir;
      bus.req_il[i] = il;
   endtask
   task automatic scramble();
      bus.req_valid = 2'($urandom);
      bus.req_sel = 8'($urandom);
      bus.req_a = 8'($urandom);
      bus.req_b = 8'($urandom);
      bus.req_cnt = 4'($urandom);
      bus.req_ci = 2'($urandom);
      bus.req_ir = 2'($urandom);
      bus.req_il = 2'($urandom);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      last_m = 1'b1;
      @(posedge clk);
      #1;
   endtask
   // one full transaction: offer v, expect grant, follow EXEC, hold RESP for hold cycles
   task automatic run_op(input logic [1:0] v, input int hold, input bit scr);
      logic w, ci, ir, il;
      logic [3:0] s, a, b, a_cur;
      logic [1:0] c;
      logic [4:0] exp_r, st;
      int e, n;
      bus.req_valid = v;
      #1;
      w = (v == 2'b11) ? ~last_m : v[1];
      chk("req_ready_grant", 32'(bus.req_ready), w ? 32'h2 : 32'h1);
      s = w ? bus.req_sel[7:4] : bus.req_sel[3:0];
      a = w ? bus.req_a[7:4] : bus.req_a[3:0];
      b = w ? bus.req_b[7:4] : bus.req_b[3:0];
      c = w ? bus.req_cnt[3:2] : bus.req_cnt[1:0];
      ci = bus.req_ci[w];
      ir = bus.req_ir[w];
      il = bus.req_il[w];
      exp_r = op_ref(s, a, b, ci, ir, il, c);
      e = s[3] ? int'(c) + 1 : 1;
      a_cur = a;
      @(posedge clk);
      #1;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         if (scr) scramble();
         #1;
         chk("exec_alu_sel", 32'(bus.alu_sel), 32'(s));
         chk("exec_alu_a", 32'(bus.alu_a), 32'(a_cur));
         chk("exec_alu_b", 32'(bus.alu_b), 32'(b));
         chk("exec_req_ready", 32'(bus.req_ready), 32'h0);
         st = alu_ref(s, a_cur, b, ci, ir, il);
         a_cur = st[3:0];
         n++;
         @(posedge clk);
         #1;
      end
      chk("exec_cycles", 32'(n), 32'(e));
      for (int k = 0; k <= hold; k++) begin
         if (scr) scramble();
         #1;
         chk("rsp_valid", 32'(bus.rsp_valid), 32'h1);
         chk("rsp_f", 32'(bus.rsp_f), 32'(exp_r[3:0]));
         chk("rsp_co", 32'(bus.rsp_co), 32'(exp_r[4]));
         chk("rsp_id", 32'(bus.rsp_id), 32'(w));
         chk("resp_req_ready", 32'(bus.req_ready), 32'h0);
         chk("resp_alu_a", 32'(bus.alu_a), 32'h0);
         got_f = bus.rsp_f;
         got_co = bus.rsp_co;
         got_id = bus.rsp_id;
         if (k < hold) begin
            @(posedge clk);
            #1;
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 2'b00;
      chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'h0);
      last_m = w;
   endtask
   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_sel = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_cnt = '0;
      bus.req_ci = '0;
      bus.req_ir = '0;
      bus.req_il = '0;
      bus.rsp_ready = 1'b0;
      #2;
      chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("reset_alu_sel", 32'(bus.alu_sel), 32'h0);
      do_reset();
      set_req(0, 4'b0001, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0);
      run_op(2'b01, 0, 1'b0);
      chk("basic_f", 32'(got_f), 32'h8);
      chk("basic_co", 32'(got_co), 32'h0);
      chk("basic_id", 32'(got_id), 32'h0);
      do_reset();
      set_req(0, 4'b0010, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0);
      set_req(1, 4'b0001, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0);
      run_op(2'b11, 0, 1'b0);
      chk("rr_first_id", 32'(got_id), 32'h0);
      chk("rr_first_f", 32'(got_f), 32'h2);
      chk("rr_first_co", 32'(got_co), 32'h1);
      run_op(2'b11, 1, 1'b0);
      chk("rr_second_id", 32'(got_id), 32'h1);
      chk("rr_second_f", 32'(got_f), 32'h8);
      run_op(2'b11, 0, 1'b0);
      chk("rr_third_id", 32'(got_id), 32'h0);
      set_req(1, 4'b1100, 4'b0011, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2);
      run_op(2'b10, 0, 1'b0);
      chk("shift_f", 32'(got_f), 32'h8);
      chk("shift_id", 32'(got_id), 32'h1);
      set_req(0, 4'b0001, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 2'd3);
      run_op(2'b01, 5, 1'b0);
      run_op(2'b01, 0, 1'b0);
      chk("backpressure_next_id", 32'(got_id), 32'h0);
      set_req(0, 4'b1100, 4'b0011, 4'd0, 1'b0, 1'b0, 1'b0, 2'd3);
      bus.req_valid = 2'b01;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("abort_in_exec", 32'(bus.alu_sel), 32'hC);
      rst_n = 1'b0;
      #1;
      chk("abort_req_ready", 32'(bus.req_ready), 32'h0);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("abort_alu", 32'({bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_ci, bus.alu_ir, bus.alu_il}), 32'h0);
      chk("abort_rsp", 32'({bus.rsp_id, bus.rsp_f, bus.rsp_co}), 32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      bus.req_valid = 2'b00;
      last_m = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         chk("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
      end
      set_req(1, 4'b0101, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0, 2'd0);
      run_op(2'b10, 0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         scramble();
         run_op(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b1);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
